muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle multiply/divide unit with its sequencing controller, attached beside the execution stage of the 5-stage processor. It accepts mult/multu/div/divu operations from execution, iterates for a fixed 32 steps, and writes the architectural HI/LO registers. It raises a stall request so the pipeline holds instructions that need HI/LO or a new multiply/divide while an operation is in flight.

Parameters:
WIDTH, 32, operand width and HI/LO width; the iteration count equals WIDTH.

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high; sampled on posedge clock
start  input  1  execution stage issues a valid mult/multu/div/divu this cycle
op  input  2  0=mult, 1=multu, 2=div, 3=divu; sampled with start
operand_a  input  WIDTH  rs value (multiplicand / dividend)
operand_b  input  WIDTH  rt value (multiplier / divisor)
hilo_read  input  1  execution stage holds mfhi/mflo this cycle
cancel  input  1  flush: abort the in-flight operation
busy  output  1  operation in flight
done  output  1  one-cycle pulse when HI/LO take a new result
stall  output  1  pipeline hold request
hi  output  WIDTH  HI register (product upper half / remainder)
lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset: state=IDLE; busy=0, done=0, stall=0, hi=0, lo=0; iteration counter=0. Reset overrides every other input, including mid-operation.
- States: IDLE -> PREP -> ITERATE -> FIXUP -> IDLE.
- IDLE: start=1 latches op and operands, then moves to PREP.
- PREP: for signed ops, latch the magnitude of each operand and the sign flags. Result sign: product and quotient = sign_a XOR sign_b; remainder = sign_a. Counter is loaded with WIDTH-1.
- ITERATE: exactly WIDTH cycles.
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, with the partial remainder one bit wider than WIDTH.
  - Leave ITERATE when the counter reaches 0.
- FIXUP: conditionally negate the results. HI/LO are written at the end of FIXUP.
- Latency: start sampled at edge k. busy is high during cycles k+1 .. k+34. hi/lo hold the new values and done=1 in cycle k+35. busy is 0 in k+35.
- Divide by zero (operand_b=0 on div/divu):
  - Skip ITERATE and go PREP -> FIXUP.
  - Result: lo=all ones, hi=operand_a unmodified.
  - done arrives in cycle k+3.
- Signed overflow: div of 0x80000000 by -1 gives lo=0x80000000, hi=0. This falls out of the magnitude path naturally; no special case is needed.
- stall = busy & (start | hilo_read). The pipeline holds the requesting instruction while stall=1. A start received while busy is ignored.
- start and done in the same cycle is legal: the new operation is accepted from IDLE in that cycle.
- cancel:
  - When busy, cancel returns to IDLE next cycle with no done and hi/lo unchanged.
  - cancel together with start in IDLE wins: the operation is not accepted.
  - cancel while IDLE and not starting has no effect.
- hi/lo change only at FIXUP completion or reset.
- Arithmetic is modulo 2^WIDTH per half; nothing traps.

Decomposition:
- Shared package holds:
  - op encodings MULDIV_MULT=2'd0, MULDIV_MULTU=2'd1, MULDIV_DIV=2'd2, MULDIV_DIVU=2'd3;
  - state encodings;
  - funct constants 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10 (mfhi), 6'h12 (mflo), which the decode stage also uses.
- One sub-module, muldiv_datapath: holds the accumulator and remainder shift registers, the adder/subtractor, and the negation logic. It is controlled by load/step/fixup strobes from the FSM in muldiv_sequencer.

Test Plan:
- multu 0xFFFFFFFF x 0xFFFFFFFF -> done at k+35; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 34 cycles.
- mult -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100 / 7 -> lo=14, hi=2. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- div 42 / 0 -> done at k+3; lo=0xFFFFFFFF, hi=42.
- Back-to-back and stall:
  - hilo_read=1 at k+5 -> stall=1 through k+34, 0 at k+35.
  - Second start at k+10 -> ignored with stall=1.
  - Re-issued start held until k+35 -> accepted; its result arrives 35 cycles later.
- cancel at k+12 -> busy=0 at k+13, no done, hi/lo keep their prior values. reset at k+20 of a fresh op -> all outputs 0 next cycle.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide unit and the decode stage.
package muldiv_sequencer_pkg;

  // Operation encodings carried on the op port
  localparam logic [1:0] MULDIV_MULT  = 2'd0;
  localparam logic [1:0] MULDIV_MULTU = 2'd1;
  localparam logic [1:0] MULDIV_DIV   = 2'd2;
  localparam logic [1:0] MULDIV_DIVU  = 2'd3;

  // R-type funct codes that touch the multiply/divide unit
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  // Sequencer states
  typedef enum logic [1:0] {
    StIdle,
    StPrep,
    StIterate,
    StFixup
  } muldiv_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MULDIV_MULT) || (op == MULDIV_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Multiply/divide datapath: operand latches, shared 2*WIDTH accumulator,
// shift-add / restoring shift-subtract step, sign fixup and HI/LO registers.
module muldiv_datapath
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             prep,
  input  logic             step,
  input  logic             fixup,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  // Multiplicand for multiply, divisor for divide
  logic [WIDTH-1:0]   addend_q;
  // Multiply: {partial product, multiplier}; divide: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_q;
  logic               neg_res_q, neg_rem_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               is_div, sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub, div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   hi_res, lo_res;

  // Operand magnitudes, one iteration step and the signed fixup results
  always_comb begin
    is_div   = op_is_div(op_q);
    sign_a   = op_is_signed(op_q) & a_q[WIDTH-1];
    sign_b   = op_is_signed(op_q) & b_q[WIDTH-1];
    mag_a    = sign_a ? -a_q : a_q;
    mag_b    = sign_b ? -b_q : b_q;
    div_zero = is_div && (b_q == '0);

    // Radix-2 shift-add: add multiplicand when the multiplier LSB is set
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? addend_q : '0)};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: partial remainder is one bit wider than WIDTH
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge    = div_shift >= {1'b0, addend_q};
    div_sub   = WIDTH'(div_shift - {1'b0, addend_q});
    div_rem   = div_ge ? div_sub : div_shift[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

    prod = neg_res_q ? -acc_q : acc_q;
    quo  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    if (div_zero) begin
      hi_res = a_q;
      lo_res = '1;
    end else if (is_div) begin
      hi_res = rem;
      lo_res = quo;
    end else begin
      hi_res = prod[2*WIDTH-1:WIDTH];
      lo_res = prod[WIDTH-1:0];
    end
  end

  // Datapath registers advanced by the sequencer strobes
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      addend_q  <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (load) begin
        op_q <= op;
        a_q  <= operand_a;
        b_q  <= operand_b;
      end
      if (prep) begin
        addend_q  <= is_div ? mag_b : mag_a;
        acc_q     <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
        neg_res_q <= sign_a ^ sign_b;
        neg_rem_q <= sign_a;
      end
      if (step) begin
        acc_q <= is_div ? div_next : mul_next;
      end
      if (fixup) begin
        hi_q <= hi_res;
        lo_q <= lo_res;
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multiply/divide sequencer: IDLE -> PREP -> ITERATE (WIDTH steps) -> FIXUP,
// with pipeline stall request and flush cancel.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hilo_read,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  muldiv_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q;
  logic            load_en, prep_en, step_en, fixup_en;
  logic            div_zero;

  // State, iteration counter and done pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= fixup_en;
    end
  end

  // Next-state: cancel aborts any in-flight operation and blocks a new start
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start && !cancel) state_d = StPrep;
      end
      StPrep: begin
        cnt_d   = CntW'(WIDTH - 1);
        state_d = div_zero ? StFixup : StIterate;
      end
      StIterate: begin
        if (cnt_q == '0) state_d = StFixup;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StFixup: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (state_q != StIdle && cancel) state_d = StIdle;
  end

  // Datapath strobes and pipeline-facing outputs
  always_comb begin
    busy     = (state_q != StIdle);
    load_en  = (state_q == StIdle) && start && !cancel;
    prep_en  = (state_q == StPrep) && !cancel;
    step_en  = (state_q == StIterate) && !cancel;
    fixup_en = (state_q == StFixup) && !cancel;
    stall    = busy && (start || hilo_read);
    done     = done_q;
  end

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clock     (clock),
    .reset     (reset),
    .load      (load_en),
    .prep      (prep_en),
    .step      (step_en),
    .fixup     (fixup_en),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo)
  );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with an expected-result scoreboard.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        hilo_read = 1'b0;
  logic        cancel = 1'b0;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  muldiv_sequencer #(
    .WIDTH(32)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .hilo_read (hilo_read),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for done (bounded), then pop the scoreboard and compare HI/LO.
  // Entered in the first cycle after the accepting edge.
  task automatic wait_done(input string tag, input int lat);
    int n;
    int busy_cycles;
    logic [63:0] e;
    n = 1;
    busy_cycles = 0;
    while (done !== 1'b1 && n < 60) begin
      if (busy === 1'b1) busy_cycles++;
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " busy cycles"}, 64'(busy_cycles), 64'(lat - 1));
    check({tag, " busy at done"}, {63'd0, busy}, 64'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, " hi"}, {32'd0, hi}, {32'd0, e[63:32]});
      check({tag, " lo"}, {32'd0, lo}, {32'd0, e[31:0]});
    end else begin
      check({tag, " scoreboard entry"}, 64'(exp_q.size()), 64'd1);
    end
    tick();
    check({tag, " done one cycle"}, {63'd0, done}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int lat);
    op = o;
    operand_a = a;
    operand_b = b;
    start = 1'b1;
    exp_q.push_back({eh, el});
    tick();
    start = 1'b0;
    wait_done(tag, lat);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, {63'd0, busy}, 64'd0);
    check({tag, " done"}, {63'd0, done}, 64'd0);
    check({tag, " stall"}, {63'd0, stall}, 64'd0);
    check({tag, " hi"}, {32'd0, hi}, 64'd0);
    check({tag, " lo"}, {32'd0, lo}, 64'd0);
  endtask

  initial begin
    int saw_done;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_all_zero("reset");

    // Arithmetic corner cases
    run_op("multu max", MULDIV_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 35);
    run_op("mult -3x5", MULDIV_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 35);
    run_op("div -7/2", MULDIV_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 35);
    run_op("divu 100/7", MULDIV_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 35);
    run_op("div ovf", MULDIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 35);
    run_op("div 42/0", MULDIV_DIV, 32'd42, 32'd0, 32'd42, 32'hFFFF_FFFF, 3);

    // Back-to-back: hilo_read from k+5, second start from k+10 held until accepted
    op = MULDIV_MULTU;
    operand_a = 32'd6;
    operand_b = 32'd7;
    start = 1'b1;
    exp_q.push_back({32'd0, 32'd42});
    tick();
    start = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      hilo_read = (c >= 5);
      if (c == 10) begin
        op = MULDIV_DIVU;
        operand_a = 32'd1000;
        operand_b = 32'd33;
      end
      start = (c >= 10);
      #1;
      check("b2b stall", {63'd0, stall}, {63'd0, (c >= 5 && c <= 34)});
      check("b2b done", {63'd0, done}, {63'd0, (c == 35)});
      if (c == 35) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("b2b first hi", {32'd0, hi}, {32'd0, e[63:32]});
        check("b2b first lo", {32'd0, lo}, {32'd0, e[31:0]});
        exp_q.push_back({32'd10, 32'd30});
      end
      tick();
    end
    start = 1'b0;
    hilo_read = 1'b0;
    wait_done("b2b second", 35);

    // Cancel at k+12: no done, HI/LO keep 10/30
    op = MULDIV_DIVU;
    operand_a = 32'hDEAD_BEEF;
    operand_b = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel busy", {63'd0, busy}, 64'd0);
    check("cancel done", {63'd0, done}, 64'd0);
    saw_done = 0;
    repeat (40) begin
      if (done === 1'b1) saw_done++;
      tick();
    end
    check("cancel no late done", 64'(saw_done), 64'd0);
    check("cancel hi kept", {32'd0, hi}, 64'd10);
    check("cancel lo kept", {32'd0, lo}, 64'd30);

    // Cancel together with start in IDLE: not accepted
    op = MULDIV_MULTU;
    operand_a = 32'd1;
    operand_b = 32'd1;
    start = 1'b1;
    cancel = 1'b1;
    tick();
    start = 1'b0;
    cancel = 1'b0;
    check("cancel+start busy", {63'd0, busy}, 64'd0);
    repeat (5) tick();
    check("cancel+start lo kept", {32'd0, lo}, 64'd30);

    // Reset at k+20 of a fresh operation
    op = MULDIV_MULT;
    operand_a = 32'd2;
    operand_b = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    reset = 1'b1;
    hilo_read = 1'b1;
    tick();
    check_all_zero("reset mid-op");
    reset = 1'b0;
    hilo_read = 1'b0;

    // Recovery after reset
    run_op("multu after reset", MULDIV_MULTU, 32'h1234_5678, 32'h10,
           32'h0000_0001, 32'h2345_6780, 35);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
